sonic_echo_responder: RTL

Emulates the HC-SR04 ultrasonic sensor end of the Trig/Echo interface. It accepts a Trig pulse from the sonic_detect initiator and answers with an Echo pulse whose width in microseconds equals a programmed distance value. The emulator stands in for the physical sensor in hardware-in-loop tests and in simulation of the FPGAng ranging path. A programmed value of 0 models "no object": the block answers with a timeout-length Echo.

---
 rtl/sonic_echo_responder.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/sonic_echo_responder.sv
// HC-SR04 sensor model: answers an accepted Trig pulse with an Echo pulse range_us microseconds wide.
// Echo rises BURST_US*CLK_DIV+3 cycles after trig is first sampled low; no backpressure, retriggers while busy are flagged and dropped.
module sonic_echo_responder #(
  parameter int CLK_DIV    = 50,
  parameter int TRIG_MIN_US = 10,
  parameter int BURST_US   = 200,
  parameter int TIMEOUT_US = 38000,
  parameter int HOLDOFF_US = 100
) (
  input  logic        clk_50m,
  input  logic        rst,
  input  logic        trig,
  input  logic [11:0] range_us,
  output logic        echo,
  output logic        busy,
  output logic        short_err,
  output logic        trig_ignored
);

  localparam int CW = 21;
  localparam logic [CW-1:0] DIV         = CW'(CLK_DIV);
  // The TRIG_HI entry cycle is itself one of the high samples, hence the -1.
  localparam logic [CW-1:0] TRIG_LIM    = CW'(TRIG_MIN_US * CLK_DIV - 1);
  localparam logic [CW-1:0] BURST_LIM   = CW'(BURST_US * CLK_DIV - 1);
  localparam logic [CW-1:0] TIMEOUT_LIM = CW'(TIMEOUT_US * CLK_DIV - 1);
  localparam logic [CW-1:0] HOLD_LIM    = CW'(HOLDOFF_US * CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_MAX     = {CW{1'b1}};

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    TRIG_HI = 3'd1,
    BURST   = 3'd2,
    ECHO    = 3'd3,
    HOLDOFF = 3'd4
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;
  logic [CW-1:0] echo_lim;
  logic [CW-1:0] echo_len;

  logic trig_s1, trig_s2, trig_s3;
  logic vld_s1, vld_s2, vld_s3;
  logic rise_q, fall_q;

  // The valid chain keeps the reset-cleared history from looking like a rising edge
  // when trig is already high at reset release.
  always_ff @(posedge clk_50m or negedge rst) begin
    if (!rst) begin
      trig_s1 <= 1'b0;
      trig_s2 <= 1'b0;
      trig_s3 <= 1'b0;
      vld_s1  <= 1'b0;
      vld_s2  <= 1'b0;
      vld_s3  <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      trig_s1 <= trig;
      trig_s2 <= trig_s1;
      trig_s3 <= trig_s2;
      vld_s1  <= 1'b1;
      vld_s2  <= vld_s1;
      vld_s3  <= vld_s2;
      rise_q  <= vld_s3 & trig_s2 & ~trig_s3;
      fall_q  <= vld_s3 & ~trig_s2 & trig_s3;
    end
  end

  always_comb begin
    cnt_inc  = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);
    echo_len = (range_us == 12'd0) ? TIMEOUT_LIM
                                   : ({9'd0, range_us} * DIV) - CW'(1);
  end

  always_ff @(posedge clk_50m or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= '0;
      echo_lim     <= '0;
      echo         <= 1'b0;
      busy         <= 1'b0;
      short_err    <= 1'b0;
      trig_ignored <= 1'b0;
    end else begin
      short_err    <= 1'b0;
      trig_ignored <= 1'b0;
      cnt          <= cnt_inc;
      case (state)
        IDLE: begin
          echo <= 1'b0;
          busy <= 1'b0;
          if (rise_q) begin
            state <= TRIG_HI;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        TRIG_HI: begin
          if (fall_q) begin
            cnt <= '0;
            if (cnt >= TRIG_LIM) begin
              state    <= BURST;
              echo_lim <= echo_len;
            end else begin
              state     <= IDLE;
              busy      <= 1'b0;
              short_err <= 1'b1;
            end
          end
        end
        BURST: begin
          trig_ignored <= rise_q;
          if (cnt == BURST_LIM) begin
            state <= ECHO;
            cnt   <= '0;
            echo  <= 1'b1;
          end
        end
        ECHO: begin
          trig_ignored <= rise_q;
          if (cnt == echo_lim) begin
            state <= HOLDOFF;
            cnt   <= '0;
            echo  <= 1'b0;
          end
        end
        HOLDOFF: begin
          trig_ignored <= rise_q;
          if (cnt == HOLD_LIM) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          echo  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
